// File: rtl/uart_cmd_parser.sv
// Framed command parser for the UART receive stream: SYNC, CMD, payload, CHK.
// Key, plaintext, delay and run-request fields commit only after the XOR checksum matches.
module uart_cmd_parser #(
  parameter int          KEY_BYTES  = 8,
  parameter int          PT_BYTES   = 4,
  parameter logic [7:0]  DELAY_INIT = 8'd15,
  parameter int          TIMEOUT    = 50000,
  parameter logic [7:0]  SYNC       = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rx_dv,
  input  logic [7:0]             rx_byte,
  input  logic                   start_ack,
  output logic [8*KEY_BYTES-1:0] key,
  output logic [8*PT_BYTES-1:0]  pt,
  output logic [7:0]             delay,
  output logic                   key_vld,
  output logic                   pt_vld,
  output logic                   delay_vld,
  output logic                   start_req,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   busy
);

  localparam int KW = 8 * KEY_BYTES;
  localparam int PW = 8 * PT_BYTES;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_PAYLOAD, S_CHK} state_e;
  typedef enum logic [1:0] {C_KEY, C_PT, C_DELAY, C_START} cmd_e;

  state_e          state, state_d;
  cmd_e            cmd, cmd_d;
  logic [7:0]      cnt, acc, len_d;
  logic [KW-1:0]   stage;
  logic [TW-1:0]   tcnt;
  logic            load_cmd, shift, commit, err_set, timeout;
  logic [1:0]      err_code_d;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == TW'(TIMEOUT)) ? v : v + TW'(1);
  endfunction

  assign timeout = (state != S_IDLE) && (tcnt == TW'(TIMEOUT));
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_d    = state;
    cmd_d      = cmd;
    len_d      = 8'd0;
    load_cmd   = 1'b0;
    shift      = 1'b0;
    commit     = 1'b0;
    err_set    = 1'b0;
    err_code_d = 2'd0;
    // A stalled frame is abandoned even if a byte arrives in the same cycle.
    if (timeout) begin
      state_d    = S_IDLE;
      err_set    = 1'b1;
      err_code_d = 2'd3;
    end else if (rx_dv) begin
      case (state)
        S_IDLE: if (rx_byte == SYNC) state_d = S_CMD;
        S_CMD: begin
          load_cmd = 1'b1;
          state_d  = S_PAYLOAD;
          case (rx_byte)
            8'h01: begin cmd_d = C_KEY;   len_d = 8'(KEY_BYTES); end
            8'h02: begin cmd_d = C_PT;    len_d = 8'(PT_BYTES);  end
            8'h03: begin cmd_d = C_DELAY; len_d = 8'd1;          end
            8'h04: begin cmd_d = C_START; state_d = S_CHK;       end
            default: begin
              load_cmd   = 1'b0;
              err_set    = 1'b1;
              err_code_d = 2'd2;
              state_d    = S_IDLE;
            end
          endcase
        end
        S_PAYLOAD: begin
          shift = 1'b1;
          if (cnt == 8'd1) state_d = S_CHK;
        end
        S_CHK: begin
          state_d = S_IDLE;
          if (rx_byte == acc) begin
            commit = 1'b1;
          end else begin
            err_set    = 1'b1;
            err_code_d = 2'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      key       <= '0;
      pt        <= '0;
      delay     <= DELAY_INIT;
      key_vld   <= 1'b0;
      pt_vld    <= 1'b0;
      delay_vld <= 1'b0;
      start_req <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_d;
      tcnt      <= (rx_dv || state == S_IDLE) ? '0 : sat_inc(tcnt);
      key_vld   <= 1'b0;
      pt_vld    <= 1'b0;
      delay_vld <= 1'b0;
      err       <= err_set;
      if (err_set) err_code <= err_code_d;
      if (start_ack) start_req <= 1'b0;
      // A START commit overrides a simultaneous acknowledge.
      if (commit) begin
        case (cmd)
          C_KEY:   begin key   <= stage;         key_vld   <= 1'b1; end
          C_PT:    begin pt    <= stage[PW-1:0]; pt_vld    <= 1'b1; end
          C_DELAY: begin delay <= stage[7:0];    delay_vld <= 1'b1; end
          C_START: start_req <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_cmd) begin
      cmd <= cmd_d;
      cnt <= len_d;
      acc <= rx_byte;
    end
    if (shift) begin
      stage <= {stage[KW-9:0], rx_byte};
      acc   <= acc ^ rx_byte;
      cnt   <= cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frames driven byte by byte, outputs checked after each frame.
module tb_uart_cmd_parser;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        start_ack = 1'b0;
  logic [63:0] key;
  logic [31:0] pt;
  logic [7:0]  delay;
  logic        key_vld, pt_vld, delay_vld, start_req, err, busy;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;

  typedef logic [7:0] bq_t [$];
  bq_t q;

  uart_cmd_parser #(.KEY_BYTES(8), .PT_BYTES(4), .DELAY_INIT(8'd15),
                    .TIMEOUT(TO), .SYNC(8'hA5)) dut (
    .clk(clk), .rstn(rstn), .rx_dv(rx_dv), .rx_byte(rx_byte), .start_ack(start_ack),
    .key(key), .pt(pt), .delay(delay), .key_vld(key_vld), .pt_vld(pt_vld),
    .delay_vld(delay_vld), .start_req(start_req), .err(err), .err_code(err_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; each call occupies exactly one clock.
  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    checks++; if (key !== 64'h0) begin errors++; $display("FAIL reset_key got=%h exp=0", key); end
    checks++; if (pt !== 32'h0) begin errors++; $display("FAIL reset_pt got=%h exp=0", pt); end
    checks++; if (delay !== 8'd15) begin errors++; $display("FAIL reset_delay got=%h exp=0f", delay); end
    checks++; if ({key_vld, pt_vld, delay_vld, start_req, err, busy} !== 6'b0)
      begin errors++; $display("FAIL reset_flags got=%b exp=000000", {key_vld, pt_vld, delay_vld, start_req, err, busy}); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
  endtask

  task automatic test_key_load;
    send(8'hA5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL key_busy_rise got=%b exp=1", busy); end
    q = '{8'h01, 8'h19, 8'h18, 8'h11, 8'h10, 8'h09, 8'h08, 8'h01, 8'h00, 8'h01};
    send_seq(q);
    checks++; if (key_vld !== 1'b1) begin errors++; $display("FAIL key_vld got=%b exp=1", key_vld); end
    checks++; if (key !== 64'h1918111009080100) begin errors++; $display("FAIL key_value got=%h exp=1918111009080100", key); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL key_busy_fall got=%b exp=0", busy); end
    idle(1);
    checks++; if (key_vld !== 1'b0) begin errors++; $display("FAIL key_vld_pulse got=%b exp=0", key_vld); end
  endtask

  task automatic test_pt_delay;
    q = '{8'hA5, 8'h02, 8'h65, 8'h65, 8'h68, 8'h77, 8'h1D};
    send_seq(q);
    checks++; if (pt_vld !== 1'b1) begin errors++; $display("FAIL pt_vld got=%b exp=1", pt_vld); end
    checks++; if (pt !== 32'h65656877) begin errors++; $display("FAIL pt_value got=%h exp=65656877", pt); end
    idle(2);
    q = '{8'hA5, 8'h03, 8'h20, 8'h23};
    send_seq(q);
    checks++; if (delay_vld !== 1'b1) begin errors++; $display("FAIL delay_vld got=%b exp=1", delay_vld); end
    checks++; if (delay !== 8'h20) begin errors++; $display("FAIL delay_value got=%h exp=20", delay); end
    idle(1);
  endtask

  task automatic test_errors;
    q = '{8'hA5, 8'h02, 8'h65, 8'h65, 8'h68, 8'h77, 8'h1E};
    send_seq(q);
    checks++; if (err !== 1'b1 || err_code !== 2'd1)
      begin errors++; $display("FAIL bad_chk got err=%b code=%0d exp err=1 code=1", err, err_code); end
    checks++; if (pt_vld !== 1'b0 || pt !== 32'h65656877)
      begin errors++; $display("FAIL bad_chk_pt got vld=%b pt=%h exp vld=0 pt=65656877", pt_vld, pt); end
    idle(1);
    checks++; if (err !== 1'b0 || err_code !== 2'd1)
      begin errors++; $display("FAIL err_hold got err=%b code=%0d exp err=0 code=1", err, err_code); end
    q = '{8'hA5, 8'h07};
    send_seq(q);
    checks++; if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0)
      begin errors++; $display("FAIL unknown_cmd got err=%b code=%0d busy=%b exp 1 2 0", err, err_code, busy); end
    idle(1);
  endtask

  task automatic test_start;
    q = '{8'hA5, 8'h04, 8'h04};
    send_seq(q);
    checks++; if (start_req !== 1'b1) begin errors++; $display("FAIL start_set got=%b exp=1", start_req); end
    idle(3);
    checks++; if (start_req !== 1'b1) begin errors++; $display("FAIL start_hold got=%b exp=1", start_req); end
    send(8'hA5);
    send(8'h04);
    start_ack = 1'b1;
    send(8'h04);
    start_ack = 1'b0;
    checks++; if (start_req !== 1'b1 || err !== 1'b0)
      begin errors++; $display("FAIL start_ack_collide got req=%b err=%b exp req=1 err=0", start_req, err); end
    start_ack = 1'b1;
    idle(1);
    start_ack = 1'b0;
    checks++; if (start_req !== 1'b0) begin errors++; $display("FAIL start_clear got=%b exp=0", start_req); end
  endtask

  task automatic test_timeout_back_to_back;
    int k;
    q = '{8'h00, 8'hFF, 8'h5A};
    send_seq(q);
    checks++; if (busy !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL garbage got busy=%b err=%b exp 0 0", busy, err); end
    q = '{8'hA5, 8'h01, 8'h19};
    send_seq(q);
    k = 0;
    for (int i = 1; i <= TO + 5; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin k = i; break; end
    end
    checks++; if (k != TO + 1) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", k, TO + 1); end
    checks++; if (err_code !== 2'd3 || busy !== 1'b0)
      begin errors++; $display("FAIL timeout_state got code=%0d busy=%b exp code=3 busy=0", err_code, busy); end
    q = '{8'hA5, 8'h03, 8'h42, 8'h41,
          8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h89};
    send_seq(q);
    checks++; if (key_vld !== 1'b1 || key !== 64'h1122334455667788)
      begin errors++; $display("FAIL b2b_key got vld=%b key=%h exp vld=1 key=1122334455667788", key_vld, key); end
    checks++; if (delay !== 8'h42) begin errors++; $display("FAIL b2b_delay got=%h exp=42", delay); end
    idle(1);
  endtask

  task automatic test_reset_mid_frame;
    q = '{8'hA5, 8'h04, 8'h04, 8'hA5, 8'h01, 8'h19, 8'h18};
    send_seq(q);
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    checks++; if (key !== 64'h0 || delay !== 8'd15 || start_req !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL mid_reset got key=%h delay=%h req=%b busy=%b exp 0 0f 0 0", key, delay, start_req, busy); end
    q = '{8'hA5, 8'h01, 8'h19, 8'h18, 8'h11, 8'h10, 8'h09, 8'h08, 8'h01, 8'h00, 8'h01};
    send_seq(q);
    checks++; if (key_vld !== 1'b1 || key !== 64'h1918111009080100)
      begin errors++; $display("FAIL post_reset_key got vld=%b key=%h exp vld=1 key=1918111009080100", key_vld, key); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_key_load();
    test_pt_delay();
    test_errors();
    test_start();
    test_timeout_back_to_back();
    test_reset_mid_frame();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Host-to-FPGA command parser. It consumes the byte stream from `uart_rx` (`o_Rx_DV` / `o_Rx_Byte`) on the UART clock domain. It assembles framed commands that load the cipher key, load the plaintext, set the sensor delay byte, and request an encryption run. It is the receive-side counterpart of the main FSM's PT/key/CT/trace transmit path. Fields are committed only after the frame checksum verifies.

## Interface
Parameters:
- `KEY_BYTES`, 8, key payload length in bytes (key width = 8*KEY_BYTES)
- `PT_BYTES`, 4, plaintext payload length in bytes
- `DELAY_INIT`, 15, reset value of `delay`
- `TIMEOUT`, 50000, idle cycles allowed between bytes inside a frame
- `SYNC`, 8'hA5, frame start byte

Ports:
- `clk`  in  1  UART/cipher clock (`clk1` at top level)
- `rstn`  in  1  reset; one clock, synchronous, active-low
- `rx_dv`  in  1  single-cycle byte strobe from `uart_rx`
- `rx_byte`  in  8  received byte, valid when `rx_dv`=1
- `start_ack`  in  1  main FSM accepts run request
- `key`  out  8*KEY_BYTES  committed key, first payload byte in MSBs
- `pt`  out  8*PT_BYTES  committed plaintext, first payload byte in MSBs
- `delay`  out  8  committed sensor delay value
- `key_vld`, `pt_vld`, `delay_vld`  out  1 each  one-cycle commit pulses
- `start_req`  out  1  level; run requested, held until acknowledged
- `err`  out  1  one-cycle error pulse
- `err_code`  out  2  1 = bad checksum, 2 = unknown command, 3 = timeout; holds its last value
- `busy`  out  1  high when the FSM is not in IDLE

## Operation
- Frame format: `SYNC`, CMD, payload, CHK.
  - CHK = XOR of CMD and all payload bytes.
- Commands and payload lengths:
  - 0x01 SET_KEY: KEY_BYTES
  - 0x02 SET_PT: PT_BYTES
  - 0x03 SET_DELAY: 1
  - 0x04 START: 0
- FSM states: IDLE, CMD, PAYLOAD, CHK. State advances only on `rx_dv`.
  - IDLE: on `rx_byte`==SYNC go to CMD. Any other byte is discarded silently.
  - CMD:
    - Known command: latch it, load the byte count, set acc = CMD. Go to PAYLOAD, or go straight to CHK if the command has no payload.
    - Unknown command: `err` pulse with code 2, return to IDLE.
  - PAYLOAD: shift the byte into the staging register (MSB-first), acc ^= byte, decrement the count. Go to CHK after the last byte.
  - CHK:
    - byte == acc: commit the staged field, pulse the matching `*_vld`. For START, set `start_req`. Return to IDLE.
    - byte != acc: `err` pulse with code 1. No output changes. Return to IDLE.
- A SYNC byte received in CMD, PAYLOAD or CHK is treated as data. Frames never resynchronise mid-frame.
- Staging register width is 8*KEY_BYTES. For SET_PT, the low 8*PT_BYTES bits are committed.
- `start_req` clears on `start_ack`=1. A START commit in the same cycle as `start_ack` leaves `start_req`=1. Repeated STARTs while pending coalesce and are not an error.
- Timeout counter:
  - Cleared on every `rx_dv` and whenever the FSM is in IDLE; saturates at TIMEOUT.
  - Reaching TIMEOUT outside IDLE: `err` pulse with code 3, go to IDLE, staged data discarded.
  - Width is $clog2(TIMEOUT+1).

## Timing
- Reset values: `key`=0, `pt`=0, `delay`=DELAY_INIT, all pulses 0, `start_req`=0, `err_code`=0, `busy`=0, state IDLE, counter 0.
- Commit latency: `key`/`pt`/`delay`, the `*_vld` pulse and `start_req` are registered. They change on the clock edge after the cycle in which the CHK byte's `rx_dv` is high.
- `err`: pulses one cycle after the offending `rx_dv`, or one cycle after the counter reaches TIMEOUT.
- `busy`: rises the cycle after the SYNC byte is accepted; falls together with the commit or error pulse.
- Back-to-back: `rx_dv` on consecutive cycles must be handled; no byte is dropped. A new SYNC may arrive on the cycle immediately after CHK.
- Reset mid-frame: everything returns to reset values on the next edge, including `start_req` and the already committed outputs.

## Test plan
- Key load: A5 01 19 18 11 10 09 08 01 00 01 -> `key`=64'h1918111009080100; `key_vld` pulses one cycle after the final strobe.
- Plaintext load: A5 02 65 65 68 77 1D -> `pt`=32'h65656877, `pt_vld` pulses. Then A5 03 20 23 -> `delay`=8'h20, `delay_vld` pulses.
- Bad checksum and unknown command:
  - A5 02 65 65 68 77 1E -> `err` pulse with `err_code`=1, `pt` unchanged.
  - A5 07 -> `err_code`=2.
- Start handshake: A5 04 04 -> `start_req`=1 until `start_ack`. A second START frame in the same cycle as `start_ack` -> `start_req` stays 1.
- Timeout, garbage and back-to-back:
  - Leading bytes 00 FF 5A are ignored.
  - A5 01 19, then TIMEOUT idle cycles -> `err_code`=3, `busy`=0.
  - A following back-to-back valid key frame with `rx_dv` every cycle commits correctly.
- Reset mid-frame: assert `rstn`=0 during a SET_KEY payload -> `key`=0, `delay`=15, `start_req`=0. The next complete frame parses normally.
